// File: rtl/multicycle_adder_module.sv
// Bit-serial-by-slice adder/subtractor: SLICE bits per cycle, LSB slice first,
// with a registered carry between slices and valid/ready on both sides.

module full_adder_gatelevel_module (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic axb;
    logic gen;
    logic prop;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign gen  = a & b;
    assign prop = axb & cin;
    assign cout = gen | prop;
endmodule

module multicycle_adder_module #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [SLICE-1:0]  a_slice;
    logic [SLICE-1:0]  b_slice;
    logic [SLICE-1:0]  slice_sum;
    logic [SLICE:0]    chain;
    int                base;

    assign base    = int'(idx) * SLICE;
    assign a_slice = a_reg[base +: SLICE];
    assign b_slice = b_reg[base +: SLICE];
    assign chain[0] = carry;

    for (genvar g = 0; g < SLICE; g++) begin : g_ripple
        full_adder_gatelevel_module u_fa (
            .a    (a_slice[g]),
            .b    (b_slice[g]),
            .cin  (chain[g]),
            .s    (slice_sum[g]),
            .cout (chain[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + !borrow_in, so the inverted operand and carry are latched at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[base +: SLICE] <= slice_sum;
                    carry              <= chain[SLICE];
                    if (idx == LAST) begin
                        cout     <= chain[SLICE];
                        overflow <= chain[SLICE] ^ chain[SLICE-1];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_adder_module.sv
// Scoreboard bench: directed 8/4 scenarios plus randomized 32/4 and 8/8 runs
// checked against a plain-arithmetic signed/unsigned reference model.

module tb_multicycle_adder_module;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic cin_v, input logic sub_v, input int acc);
        exp_t   e;
        longint mask, ua, ub, sa, sb, c, raw, sres, hi, lo;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = ((ua >> (w - 1)) & 1) != 0 ? ua - (longint'(1) << w) : ua;
        sb   = ((ub >> (w - 1)) & 1) != 0 ? ub - (longint'(1) << w) : ub;
        c    = cin_v ? 1 : 0;
        raw  = sub_v ? ua - ub - c : ua + ub + c;
        sres = sub_v ? sa - sb - c : sa + sb + c;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        e.sum  = 64'(raw & mask);
        e.cout = sub_v ? (raw >= 0) : (((raw >> w) & 1) != 0);
        e.ovf  = (sres > hi) || (sres < lo);
        e.acc  = acc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Directed DUT, 8-bit operands in 4-bit slices
    localparam int D_NS = 2;
    logic       d_reset = 1'b1;
    logic       d_in_valid = 1'b0;
    logic       d_cin = 1'b0;
    logic       d_sub = 1'b0;
    logic [7:0] d_a = '0;
    logic [7:0] d_b = '0;
    logic       d_in_ready, d_out_valid, d_out_ready, d_cout, d_overflow, d_busy;
    logic [7:0] d_sum;
    bit         d_hold = 1'b0;
    bit         d_seen = 1'b0;
    exp_t       dq[$];

    assign d_out_ready = !d_hold;

    multicycle_adder_module #(.WIDTH(8), .SLICE(4)) u_dut (
        .clk       (clk),
        .reset     (d_reset),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .a         (d_a),
        .b         (d_b),
        .cin       (d_cin),
        .sub       (d_sub),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .sum       (d_sum),
        .cout      (d_cout),
        .overflow  (d_overflow),
        .busy      (d_busy)
    );

    always @(negedge clk) begin
        exp_t e;
        if (!d_reset && d_out_valid) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL d_unexpected: out_valid=1 required=no pending result");
            end else begin
                if (!d_seen) checkOutput("d_latency", 64'(cyc - dq[0].acc), 64'(D_NS));
                if (d_out_ready) begin
                    e = dq.pop_front();
                    checkOutput("d_sum", 64'(d_sum), e.sum);
                    checkOutput("d_cout", 64'(d_cout), 64'(e.cout));
                    checkOutput("d_overflow", 64'(d_overflow), 64'(e.ovf));
                    d_seen = 1'b0;
                end else begin
                    d_seen = 1'b1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic sv, input bit track);
        int guard;
        guard = 0;
        @(negedge clk);
        d_a = av; d_b = bv; d_cin = cv; d_sub = sv; d_in_valid = 1'b1;
        while (!d_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!d_in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL d_accept_timeout: in_ready=0 required=1");
        end else if (track) begin
            dq.push_back(model(8, 64'(av), 64'(bv), cv, sv, cyc + 1));
        end
        @(negedge clk);
        d_in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (dq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (dq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL d_drain_timeout: pending=%0d required=0", dq.size());
        end
        @(negedge clk);
    endtask

    // Randomized DUTs
    logic r_reset = 1'b1;

    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int W  = (g == 0) ? 32 : 8;
        localparam int S  = (g == 0) ? 4 : 8;
        localparam int NS = W / S;
        logic         in_valid, in_ready, cin, sub, out_valid, cout, overflow, busy;
        logic         out_ready = 1'b0;
        logic [W-1:0] a, b, sum;
        exp_t         q[$];
        bit           done = 1'b0;
        bit           seen = 1'b0;

        multicycle_adder_module #(.WIDTH(W), .SLICE(S)) u_rdut (
            .clk       (clk),
            .reset     (r_reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .overflow  (overflow),
            .busy      (busy)
        );

        initial begin
            int guard;
            in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            repeat (5) @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                a   = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
                b   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom());
                cin = 1'($urandom());
                sub = 1'($urandom());
                in_valid = 1'b1;
                guard = 0;
                while (!in_ready && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                if (!in_ready) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL w%0d_accept_timeout: in_ready=0 required=1", W);
                end else begin
                    q.push_back(model(W, 64'(a), 64'(b), cin, sub, cyc + 1));
                end
                @(negedge clk);
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            guard = 0;
            while (q.size() != 0 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (q.size() != 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL w%0d_drain_timeout: pending=%0d required=0", W, q.size());
            end
            done = 1'b1;
        end

        // Result is compared every cycle it is presented, which also covers stability during stalls
        always @(negedge clk) begin
            exp_t e;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!r_reset && out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL w%0d_unexpected: out_valid=1 required=no pending result", W);
                end else begin
                    e = q[0];
                    if (!seen) checkOutput($sformatf("w%0d_latency", W), 64'(cyc - e.acc), 64'(NS));
                    checkOutput($sformatf("w%0d_sum", W), 64'(sum), e.sum);
                    checkOutput($sformatf("w%0d_cout", W), 64'(cout), 64'(e.cout));
                    checkOutput($sformatf("w%0d_overflow", W), 64'(overflow), 64'(e.ovf));
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end else begin
                        seen = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 64'(d_in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(d_out_valid), 64'd0);
        checkOutput("rst_busy", 64'(d_busy), 64'd0);
        checkOutput("rst_sum", 64'(d_sum), 64'd0);
        checkOutput("rst_cout", 64'(d_cout), 64'd0);
        checkOutput("rst_overflow", 64'(d_overflow), 64'd0);
        d_reset = 1'b0;
        r_reset = 1'b0;

        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1); waitDrain();
        applyStimulus(8'h05, 8'h07, 1'b0, 1'b1, 1'b1); waitDrain();
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 1'b1); waitDrain();
        applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1); waitDrain();

        // Hold the result while fresh operands sit on the input
        d_hold = 1'b1;
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        guard = 0;
        while (!d_out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        d_a = 8'hAA; d_b = 8'h55; d_sub = 1'b1; d_in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_out_valid", 64'(d_out_valid), 64'd1);
            checkOutput("stall_in_ready", 64'(d_in_ready), 64'd0);
            checkOutput("stall_sum", 64'(d_sum), 64'h46);
            checkOutput("stall_cout", 64'(d_cout), 64'd0);
            checkOutput("stall_overflow", 64'(d_overflow), 64'd0);
        end
        d_in_valid = 1'b0;
        d_hold = 1'b0;
        waitDrain();
        repeat (3) @(negedge clk);
        checkOutput("no_capture_busy", 64'(d_busy), 64'd0);
        checkOutput("no_capture_out_valid", 64'(d_out_valid), 64'd0);

        // Abort an operation in its second slice
        applyStimulus(8'h3C, 8'h4B, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("run_busy", 64'(d_busy), 64'd1);
        checkOutput("run_in_ready", 64'(d_in_ready), 64'd0);
        d_reset = 1'b1;
        @(negedge clk);
        d_reset = 1'b0;
        checkOutput("abort_in_ready", 64'(d_in_ready), 64'd1);
        checkOutput("abort_out_valid", 64'(d_out_valid), 64'd0);
        checkOutput("abort_busy", 64'(d_busy), 64'd0);
        checkOutput("abort_sum", 64'(d_sum), 64'd0);
        applyStimulus(8'h3C, 8'h4B, 1'b1, 1'b1, 1'b1); waitDrain();

        guard = 0;
        while (!(g_rand[0].done && g_rand[1].done) && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        if (!(g_rand[0].done && g_rand[1].done)) begin
            checks++;
            errors++;
            $display("[TB] FAIL random_timeout: done=%0b%0b required=11", g_rand[0].done, g_rand[1].done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
